// File: rtl/toksync_pkg.sv
// Shared types and constants for the token-synchronisation packet blocks.
// The check-word option is selected at build time with TOKSYNC_CHK_EN.
package toksync_pkg;

  localparam logic       HdrMarker = 1'b1;
  localparam logic [2:0] BlkSync   = 3'd5;
  localparam int unsigned TimeWordW = 15;

  typedef enum logic [2:0] {
    StIdle,
    StHdr,
    StTok,
    StTime,
    StChk
  } state_e;

  // Number of 15-bit words needed to carry a time value of the given width.
  function automatic int unsigned nwords(input int unsigned time_w);
    return (time_w + TimeWordW - 1) / TimeWordW;
  endfunction

endpackage

// File: rtl/gtime_ctr.sv
// Free-running global time counter with synchronous clear.
// Wraps naturally at 2^Width; reusable by any trigger block on the same clock.
module gtime_ctr #(
  parameter int unsigned Width = 45
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr_i,
  output logic [Width-1:0] cnt_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = clr_i ? '0 : cnt_q + Width'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/toksync_pkt.sv
// Emits a type-5 sync packet carrying GTIME on period-boundary tokens, with a
// one-deep pending slot and lost-trigger accounting. TOKSYNC_CHK_EN adds an XOR check word.
module toksync_pkt
  import toksync_pkg::*;
#(
  parameter int unsigned TIME_W      = 45,
  parameter int unsigned PERIOD_LOG2 = 8,
  parameter logic [2:0]  BLK_TYPE    = BlkSync,
  parameter int unsigned LOST_W      = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [9:0]        token,
  input  logic              tok_rdy,
  input  logic              inhibit,
  input  logic              enable,
  input  logic              tok_ack,
  output logic [15:0]       tok_dat,
  output logic              tok_vld,
  output logic              tok_lost,
  output logic [LOST_W-1:0] lost_cnt
);

  localparam int unsigned NW   = nwords(TIME_W);
  localparam int unsigned PadW = NW * TimeWordW;
  localparam int unsigned IdxW = (NW > 1) ? $clog2(NW) : 1;
`ifdef TOKSYNC_CHK_EN
  localparam int unsigned L = NW + 2;
`else
  localparam int unsigned L = NW + 1;
`endif

  logic [TIME_W-1:0] gtime;

  gtime_ctr #(
    .Width (TIME_W)
  ) u_gtime_ctr (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (inhibit),
    .cnt_o (gtime)
  );

  state_e            state_q, state_d;
  logic [IdxW-1:0]   idx_q, idx_d;
  logic [TIME_W-1:0] cur_time_q, cur_time_d;
  logic [9:0]        cur_tok_q, cur_tok_d;
  logic              cur_par_q, cur_par_d;
  logic              pend_vld_q, pend_vld_d;
  logic [TIME_W-1:0] pend_time_q, pend_time_d;
  logic [9:0]        pend_tok_q, pend_tok_d;
  logic              blk_par_q, blk_par_d;
  logic              lost_q, lost_d;
  logic [LOST_W-1:0] lost_cnt_q, lost_cnt_d;

  logic              trig;
  logic              done, start_trig, start_pend;
  logic [PadW-1:0]   time_pad;
  logic [14:0]       time_word;

  assign trig = tok_rdy && enable && !inhibit && (token[PERIOD_LOG2-1:0] == '0);

  always_comb begin
    time_pad                = '0;
    time_pad[TIME_W-1:0]    = cur_time_q;
    time_word               = time_pad[int'(idx_q)*TimeWordW +: TimeWordW];
  end

`ifdef TOKSYNC_CHK_EN
  logic [14:0] chk_q, chk_d;

  always_comb begin
    chk_d = chk_q;
    if (state_q == StHdr) begin
      chk_d = '0;
    end else if ((state_q == StTok || state_q == StTime) && tok_ack) begin
      chk_d = chk_q ^ tok_dat[14:0];
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) chk_q <= '0;
    else        chk_q <= chk_d;
  end
`endif

  always_comb begin
    tok_dat = '0;
    unique case (state_q)
      StHdr:   tok_dat = {HdrMarker, 6'b0, 9'(L)};
      StTok:   tok_dat = {1'b0, BLK_TYPE, cur_par_q, 1'b0, cur_tok_q};
      StTime:  tok_dat = {1'b0, time_word};
`ifdef TOKSYNC_CHK_EN
      StChk:   tok_dat = {1'b0, chk_q};
`endif
      default: tok_dat = '0;
    endcase
  end

  assign tok_vld  = (state_q != StIdle);
  assign tok_lost = lost_q;
  assign lost_cnt = lost_cnt_q;

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cur_time_d  = cur_time_q;
    cur_tok_d   = cur_tok_q;
    cur_par_d   = cur_par_q;
    pend_vld_d  = pend_vld_q;
    pend_time_d = pend_time_q;
    pend_tok_d  = pend_tok_q;
    blk_par_d   = blk_par_q;
    lost_d      = 1'b0;
    lost_cnt_d  = lost_cnt_q;
    done        = 1'b0;
    start_trig  = 1'b0;
    start_pend  = 1'b0;

    unique case (state_q)
      StIdle: start_trig = trig;
      StHdr:  if (tok_ack) state_d = StTok;
      StTok: begin
        if (tok_ack) begin
          state_d = StTime;
          idx_d   = '0;
        end
      end
      StTime: begin
        if (tok_ack) begin
          if (idx_q == IdxW'(NW - 1)) begin
`ifdef TOKSYNC_CHK_EN
            state_d = StChk;
`else
            done    = 1'b1;
`endif
          end else begin
            idx_d = idx_q + IdxW'(1);
          end
        end
      end
`ifdef TOKSYNC_CHK_EN
      StChk:  if (tok_ack) done = 1'b1;
`endif
      default: state_d = StIdle;
    endcase

    // Final word accepted: chain straight into the next packet if one is waiting.
    if (done) begin
      state_d   = StIdle;
      blk_par_d = ~blk_par_q;
      if (pend_vld_q && !inhibit) begin
        start_pend = 1'b1;
        pend_vld_d = 1'b0;
      end else begin
        start_trig = trig;
      end
    end

    if (start_pend) begin
      state_d    = StHdr;
      cur_time_d = pend_time_q;
      cur_tok_d  = pend_tok_q;
      cur_par_d  = blk_par_d;
    end else if (start_trig) begin
      state_d    = StHdr;
      cur_time_d = gtime;
      cur_tok_d  = token;
      cur_par_d  = blk_par_d;
    end

    if (trig && !start_trig) begin
      if (!pend_vld_d) begin
        pend_vld_d  = 1'b1;
        pend_time_d = gtime;
        pend_tok_d  = token;
      end else begin
        lost_d = 1'b1;
        if (lost_cnt_q != '1) lost_cnt_d = lost_cnt_q + LOST_W'(1);
      end
    end

    if (inhibit) begin
      pend_vld_d = 1'b0;
      blk_par_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      idx_q       <= '0;
      cur_time_q  <= '0;
      cur_tok_q   <= '0;
      cur_par_q   <= 1'b0;
      pend_vld_q  <= 1'b0;
      pend_time_q <= '0;
      pend_tok_q  <= '0;
      blk_par_q   <= 1'b0;
      lost_q      <= 1'b0;
      lost_cnt_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cur_time_q  <= cur_time_d;
      cur_tok_q   <= cur_tok_d;
      cur_par_q   <= cur_par_d;
      pend_vld_q  <= pend_vld_d;
      pend_time_q <= pend_time_d;
      pend_tok_q  <= pend_tok_d;
      blk_par_q   <= blk_par_d;
      lost_q      <= lost_d;
      lost_cnt_q  <= lost_cnt_d;
    end
  end

endmodule

// File: doc/toksync_pkt.md
Name: toksync_pkt

Overview:
Parametrised successor to the token-synchronisation block. It emits a type-5 sync packet into the memory FIFO carrying a free-running global time (GTIME) whenever a token hits a configurable period boundary. Adds several features:
- width-generic GTIME
- FIFO backpressure (valid/ack)
- one-deep pending-trigger slot
- lost-trigger accounting
Sits between the GTP token receiver and the event FIFO, on the same clk.

Parameters:
TIME_W, 45, GTIME width (15..135); time words NW = ceil(TIME_W/15)
PERIOD_LOG2, 8, trigger when token[PERIOD_LOG2-1:0]==0 (1..10)
BLK_TYPE, 3'd5, trigger block type field
LOST_W, 8, width of saturating lost-trigger counter

Ports:
clk  in  1  GTP clock, all logic on rising edge
rst_n  in  1  reset; one clock; reset is synchronous and active-low
token  in  10  trigger token
tok_rdy  in  1  token strobe, one cycle per token
inhibit  in  1  global inhibit
enable  in  1  enable sync packets
tok_ack  in  1  FIFO accepts word (not full)
tok_dat  out  16  data word to FIFO
tok_vld  out  1  tok_dat valid
tok_lost  out  1  one-cycle pulse: trigger dropped
lost_cnt  out  LOST_W  saturating count of dropped triggers

Behaviour:
- Reset (rst_n=0 at edge): all of the following cleared, with no packet in progress:
  - tok_dat=0, tok_vld=0, tok_lost=0, lost_cnt=0
  - GTIME=0, blk_par=0, pending slot empty, state IDLE
- GTIME: +1 every cycle, wraps at 2^TIME_W. Cleared to 0 while inhibit=1.
- Trigger: tok_rdy && enable && !inhibit && token[PERIOD_LOG2-1:0]==0. Captures {GTIME (pre-increment value that cycle), token}.
- Packet: L+1 words, L = NW+1 (+1 with CHK).
  - W0 header: {1'b1, 6'b0, L[8:0]}
  - W1: {1'b0, BLK_TYPE, blk_par, 1'b0, token}
  - W2..W(NW+1): {1'b0, GTIMES[15k+14:15k]}, k=0..NW-1; bits above TIME_W zero.
- Handshake:
  - A word transfers on tok_vld && tok_ack.
  - tok_dat/tok_vld stay stable while tok_vld && !tok_ack.
  - No bubbles while tok_ack is held high.
- Latency: trigger sampled at cycle T, so W0 is valid at T+1 (when idle). With tok_ack=1, the last word is at T+L+1.
- States:
  - IDLE: on capture go to HDR.
  - HDR: to TOK on ack.
  - TOK: to TIME on ack.
  - TIME: word index idx counts 0..NW-1, advancing on ack; after the last time word, go to CHK (if enabled) else DONE.
  - DONE: combinational; returns to IDLE, or directly to HDR if pending is full, consuming pending. No idle cycle is required between back-to-back packets.
- Trigger while busy: stored in the pending slot if empty. If the slot is full, the trigger is dropped: tok_lost pulses and lost_cnt increments, saturating at all-ones.
- Trigger on the same cycle the packet completes: goes to pending (or is consumed immediately); it is never lost.
- blk_par: toggles when a packet's final word is accepted. Forced to 0 while inhibit=1, and the toggle is suppressed in that case.
- Inhibit mid-packet: the packet in flight completes unchanged (FIFO stream integrity). The pending slot is cleared and new triggers are blocked.
- Reset mid-packet: the packet is abandoned immediately and tok_vld drops the next cycle.
- enable=0: only blocks new triggers; in-flight and pending packets still go out.

Optional Feature:
TOKSYNC_CHK_EN:
- Defined: one extra final word {1'b0, XOR of bits[14:0] of W1..last time word}, and L = NW+2.
- Undefined: no check word, L = NW+1; the logic is absent.

Decomposition:
- Package toksync_pkg holds:
  - header marker constant 1'b1
  - block-type codes (SYNC=3'd5)
  - function nwords(TIME_W)
  - state enum {IDLE, HDR, TOK, TIME, CHK}
- One natural sub-module: gtime_ctr, a TIME_W-bit free-running counter with synchronous clear. It is reusable by other trigger blocks.

Test Plan:
1. Defaults, tok_ack=1, trigger token=10'h100 at GTIME=0x1234 -> at T+1..T+5: 8004, 5100, 1234, 0000, 0000; next packet has p=1.
2. tok_ack toggled 1-0-1 per cycle -> same five words in order, each held stable while ack=0, none duplicated.
3. tok_ack=0 held, three triggers (tokens 0x000, 0x100, 0x200) -> first in flight, second pending, third dropped with tok_lost pulse and lost_cnt=1; releasing ack yields two packets back-to-back.
4. Inhibit asserted during W2 -> packet completes, next W1 has p=0, GTIME restarts at 0 after inhibit falls.
5. TIME_W=50 (NW=4) -> header 8005; top time word = {1'b0, 10'b0, GTIMES[49:45]}.
6. TOKSYNC_CHK_EN defined, test 1 stimulus -> header 8005, last word = 0x5100^0x1234^0^0 masked to 15 bits = 0x4334.
